// File: rtl/bp_ckpt_ctrl_pkg.sv
// Shared types and helpers for the BHT checkpoint sequencer.
// Optional clear sweep of bank B is enabled with `define BP_CKPT_CLEAR_EN.
package bp_ckpt_ctrl_pkg;

  // Default in-flight limit of the frontend and the counter width it implies.
  localparam int unsigned BP_CKPT_MAX_INFLIGHT = 16;
  localparam int unsigned BP_CKPT_CNT_W        = $clog2(BP_CKPT_MAX_INFLIGHT + 1);

  // Sequencer states. CLEAR_B only exists when the sweep is built in.
  typedef enum logic [2:0] {
    ST_RUN_A      = 3'd0,
    ST_DRAIN_TO_B = 3'd1,
`ifdef BP_CKPT_CLEAR_EN
    ST_CLEAR_B    = 3'd2,
`endif
    ST_RUN_B      = 3'd3,
    ST_DRAIN_TO_A = 3'd4
  } bp_ckpt_state_e;

  // Width of a counter holding 0..max_val inclusive.
  function automatic int unsigned bp_cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index over n entries.
  function automatic int unsigned bp_idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bank B stays selected while draining back to A: the old bank keeps
  // receiving updates until its in-flight branches are gone.
  function automatic logic bp_is_bank_b(input bp_ckpt_state_e s);
    return (s == ST_RUN_B) || (s == ST_DRAIN_TO_A);
  endfunction

endpackage

// File: rtl/bp_ckpt_ctrl_if.sv
// Handshake and status bundle between the checkpoint sequencer and the
// frontend (request source, branch tracking, bht_mux steering).
//
// Request handshake: ckpt_req_valid_i is held by the requester until a
// cycle where ckpt_req_ready_o is also high; that edge is the acceptance.
// ready only depends on registered state, never on valid.
interface bp_ckpt_ctrl_if
  import bp_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024
) ();
  localparam int unsigned IDX_W = bp_idx_width(NR_ENTRIES);

  logic             flush_i;
  logic             ckpt_req_valid_i;
  logic             ckpt_req_ready_o;
  logic             branch_issue_i;
  logic             branch_resolve_i;
  logic             checkpoint_mode_o;
  logic             update_en_o;
  logic             clr_valid_o;
  logic [IDX_W-1:0] clr_index_o;
  logic             busy_o;
  logic             drain_timeout_o;

  // Sequencer side.
  modport slave (
    input  flush_i, ckpt_req_valid_i, branch_issue_i, branch_resolve_i,
    output ckpt_req_ready_o, checkpoint_mode_o, update_en_o, clr_valid_o,
           clr_index_o, busy_o, drain_timeout_o
  );

  // Frontend / requester side.
  modport master (
    output flush_i, ckpt_req_valid_i, branch_issue_i, branch_resolve_i,
    input  ckpt_req_ready_o, checkpoint_mode_o, update_en_o, clr_valid_o,
           clr_index_o, busy_o, drain_timeout_o
  );
endinterface

// File: rtl/bp_inflight_cnt.sv
// Saturating up/down counter of unresolved branches with a flush that
// zeroes it. A same-cycle increment is dropped on flush; simultaneous
// increment and decrement cancel; decrement at zero is ignored.
module bp_inflight_cnt #(
  parameter int unsigned MAX_VAL = 16,
  parameter int unsigned W       = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX_VAL);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: flush wins, then single-sided inc/dec with clamping.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != MAX_V) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/bp_ckpt_ctrl.sv
// Bank sequencer for the dual-bank BHT behind bht_mux. Switches between
// bank A and bank B only after in-flight branch updates drain (or a drain
// timeout forces it). With `define BP_CKPT_CLEAR_EN bank B is swept to
// zero on every entry; without it bank B keeps its previous contents.
module bp_ckpt_ctrl
  import bp_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES    = 1024,
  parameter int unsigned MAX_INFLIGHT  = 16,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  bp_ckpt_ctrl_if.slave  bus,
  output bp_ckpt_state_e dbg_state_o
);
  localparam int unsigned CNT_W    = bp_cnt_width(MAX_INFLIGHT);
  localparam int unsigned TMR_W    = (DRAIN_TIMEOUT < 2) ? 1 : $clog2(DRAIN_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam int unsigned IDX_W    = bp_idx_width(NR_ENTRIES);

  bp_ckpt_state_e   state_d, state_q;
  logic [TMR_W-1:0] timer_d, timer_q;
  logic             mode_d, mode_q;
  logic             ready_d, ready_q;
  logic             busy_d, busy_q;
  logic             timeout_d, timeout_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             drain_idle;
  logic             timer_hit;
  logic             force_zero;

`ifdef BP_CKPT_CLEAR_EN
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_ENTRIES - 1);
  logic             clr_valid_d, clr_valid_q;
  logic [IDX_W-1:0] clr_idx_d, clr_idx_q;
`endif

  // A timed-out drain also zeroes the counter: those branches are given up.
  bp_inflight_cnt #(
    .MAX_VAL (MAX_INFLIGHT),
    .W       (CNT_W)
  ) u_inflight_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.flush_i | force_zero),
    .inc_i   (bus.branch_issue_i),
    .dec_i   (bus.branch_resolve_i),
    .cnt_o   (cnt)
  );

  // A resolve seen with the counter at zero still has its BHT write in the
  // registered update path of bht_mux, so the drain waits one more cycle.
  assign cnt_zero   = (cnt == '0);
  assign drain_idle = cnt_zero & ~bus.branch_resolve_i;
  assign timer_hit  = (timer_q == TMR_LAST);

  // Next-state, drain timer, sweep index and next registered outputs.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    timeout_d  = 1'b0;
    force_zero = 1'b0;
`ifdef BP_CKPT_CLEAR_EN
    clr_idx_d  = clr_idx_q;
`endif
    case (state_q)
      ST_RUN_A: begin
        if (bus.ckpt_req_valid_i) state_d = ST_DRAIN_TO_B;
      end
      ST_DRAIN_TO_B: begin
        if (drain_idle || timer_hit) begin
`ifdef BP_CKPT_CLEAR_EN
          state_d   = ST_CLEAR_B;
          clr_idx_d = '0;
`else
          state_d   = ST_RUN_B;
`endif
          timeout_d  = ~drain_idle;
          force_zero = ~drain_idle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef BP_CKPT_CLEAR_EN
      ST_CLEAR_B: begin
        if (clr_idx_q == IDX_LAST) begin
          state_d   = ST_RUN_B;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
`endif
      ST_RUN_B: begin
        if (bus.ckpt_req_valid_i) state_d = ST_DRAIN_TO_A;
      end
      ST_DRAIN_TO_A: begin
        if (drain_idle || timer_hit) begin
          state_d    = ST_RUN_A;
          timeout_d  = ~drain_idle;
          force_zero = ~drain_idle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_RUN_A;
    endcase
    mode_d  = bp_is_bank_b(state_d);
    ready_d = (state_d == ST_RUN_A) || (state_d == ST_RUN_B);
    busy_d  = ~ready_d;
`ifdef BP_CKPT_CLEAR_EN
    clr_valid_d = (state_d == ST_CLEAR_B);
`endif
  end

  // State and registered outputs; reset abandons any drain or sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN_A;
      timer_q     <= '0;
      mode_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef BP_CKPT_CLEAR_EN
      clr_valid_q <= 1'b0;
      clr_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mode_q      <= mode_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
`ifdef BP_CKPT_CLEAR_EN
      clr_valid_q <= clr_valid_d;
      clr_idx_q   <= clr_idx_d;
`endif
    end
  end

  assign bus.checkpoint_mode_o = mode_q;
  assign bus.ckpt_req_ready_o  = ready_q;
  assign bus.busy_o            = busy_q;
  assign bus.drain_timeout_o   = timeout_q;
`ifdef BP_CKPT_CLEAR_EN
  assign bus.clr_valid_o       = clr_valid_q;
  assign bus.clr_index_o       = clr_idx_q;
  assign bus.update_en_o       = ~clr_valid_q;
`else
  assign bus.clr_valid_o       = 1'b0;
  assign bus.clr_index_o       = '0;
  assign bus.update_en_o       = 1'b1;
`endif
  assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_bp_ckpt_ctrl.sv
// Bench for bp_ckpt_ctrl: directed latency scenarios plus randomized
// traffic against a cycle-level behavioural model. Handles both builds
// (BP_CKPT_CLEAR_EN defined or not).
module tb_bp_ckpt_ctrl;
  import bp_ckpt_ctrl_pkg::*;

  localparam int NR   = 16;
  localparam int MAXI = 6;
  localparam int TO   = 16;
`ifdef BP_CKPT_CLEAR_EN
  localparam int SWEEP = NR;
`else
  localparam int SWEEP = 0;
`endif
  localparam int IW = $clog2(NR);
  localparam int VW = 6 + IW;
  // {mode, ready, update_en, clr_valid, clr_index, busy, drain_timeout}
  localparam logic [VW-1:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, {IW{1'b0}}, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_ckpt_ctrl_if #(.NR_ENTRIES(NR)) bus();
  bp_ckpt_state_e dbg_state;

  bp_ckpt_ctrl #(
    .NR_ENTRIES    (NR),
    .MAX_INFLIGHT  (MAXI),
    .DRAIN_TIMEOUT (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [VW-1:0] exp_q[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Tracks which bank is live, whether a drain or sweep is in progress and
  // how many branches are outstanding, directly from the behavioural rules.
  int m_out, m_dcyc, m_idx;
  bit m_bank_b, m_drain, m_sweep, m_to;

  function automatic void model_reset();
    m_out = 0; m_dcyc = 0; m_idx = 0;
    m_bank_b = 0; m_drain = 0; m_sweep = 0; m_to = 0;
  endfunction

  function automatic void model_step(bit req, bit iss, bit res, bit fl);
    bit ready  = !m_drain && !m_sweep;
    bit done   = 0;
    bit forced = 0;
    if (m_drain) begin
      if (m_out == 0 && !res) done = 1;
      else if (m_dcyc == TO - 1) begin done = 1; forced = 1; end
    end
    if (fl || forced)        m_out = 0;
    else if (iss && !res)    m_out = (m_out < MAXI) ? m_out + 1 : MAXI;
    else if (res && !iss && m_out > 0) m_out = m_out - 1;
    m_to = forced;
    if (m_drain) begin
      if (done) begin
        m_drain = 0; m_dcyc = 0;
        if (m_bank_b)       m_bank_b = 0;
        else if (SWEEP > 0) begin m_sweep = 1; m_idx = 0; end
        else                m_bank_b = 1;
      end else begin
        m_dcyc++;
      end
    end else if (m_sweep) begin
      if (m_idx == NR - 1) begin m_sweep = 0; m_idx = 0; m_bank_b = 1; end
      else m_idx++;
    end else if (req && ready) begin
      m_drain = 1; m_dcyc = 0;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [IW-1:0] idx = IW'(m_sweep ? m_idx : 0);
    bit rdy = !m_drain && !m_sweep;
    return {m_bank_b, rdy, !m_sweep, m_sweep, idx, !rdy, m_to};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.checkpoint_mode_o, bus.ckpt_req_ready_o, bus.update_en_o, bus.clr_valid_o,
            bus.clr_index_o, bus.busy_o, bus.drain_timeout_o};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_in(input bit req, input bit iss, input bit res, input bit fl);
    bus.ckpt_req_valid_i = req;
    bus.branch_issue_i   = iss;
    bus.branch_resolve_i = res;
    bus.flush_i          = fl;
  endtask

  // One clock edge with the current inputs; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    model_step(bus.ckpt_req_valid_i, bus.branch_issue_i, bus.branch_resolve_i, bus.flush_i);
    #1;
  endtask

  // Return to bank A, idle, with no outstanding branches.
  task automatic go_home();
    int guard = 0;
    while (!(bus.checkpoint_mode_o == 1'b0 && bus.ckpt_req_ready_o == 1'b1) && guard < 200) begin
      set_in(bus.checkpoint_mode_o & bus.ckpt_req_ready_o, 1'b0, 1'b0, 1'b1);
      tick();
      guard++;
    end
    n_total++;
    if (guard >= 200)
      $display("FAIL go_home: mode=%0b ready=%0b, want mode=0 ready=1",
               bus.checkpoint_mode_o, bus.ckpt_req_ready_o);
    else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_total++;
    if (obs_vec() !== RESET_VEC) $display("FAIL reset_values: got %h want %h", obs_vec(), RESET_VEC);
    else n_pass++;
    rst_ni = 1'b1;
    tick();
    n_total++;
    if (obs_vec() !== RESET_VEC) $display("FAIL reset_idle: got %h want %h", obs_vec(), RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_idle_enter();
    go_home();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.ckpt_req_ready_o, bus.checkpoint_mode_o, bus.busy_o} !== 3'b001)
      $display("FAIL enter_t1: ready/mode/busy got %b%b%b want 001",
               bus.ckpt_req_ready_o, bus.checkpoint_mode_o, bus.busy_o);
    else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 3 + SWEEP; c++) begin
      tick();
      n_total++;
      if (bus.checkpoint_mode_o !== logic'(c >= 2 + SWEEP))
        $display("FAIL enter_mode t+%0d: got %b want %b", c, bus.checkpoint_mode_o, c >= 2 + SWEEP);
      else n_pass++;
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.checkpoint_mode_o, bus.ckpt_req_ready_o} !== 2'b10)
      $display("FAIL exit_t1: mode/ready got %b%b want 10", bus.checkpoint_mode_o, bus.ckpt_req_ready_o);
    else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.checkpoint_mode_o, bus.ckpt_req_ready_o} !== 2'b01)
      $display("FAIL exit_t2: mode/ready got %b%b want 01", bus.checkpoint_mode_o, bus.ckpt_req_ready_o);
    else n_pass++;
  endtask

  // 3 outstanding, resolves at t+5..t+7; overlap adds issue+resolve at t+6
  // and one more resolve at t+8.
  task automatic test_drain_wait(input bit ovl);
    int rise = (ovl ? 10 : 9) + SWEEP;
    go_home();
    issue_n(3);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 11 + SWEEP; c++) begin
      set_in(1'b0, ovl && c == 6, (c >= 5 && c <= 7) || (ovl && c == 8), 1'b0);
      tick();
      n_total++;
      if (bus.checkpoint_mode_o !== logic'(c + 1 >= rise))
        $display("FAIL drain_wait ovl=%0b t+%0d: mode got %b want %b", ovl, c + 1,
                 bus.checkpoint_mode_o, c + 1 >= rise);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    go_home();
    issue_n(2);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= TO + 3 + SWEEP; c++) begin
      tick();
      n_total++;
      if ({bus.drain_timeout_o, bus.checkpoint_mode_o} !== {logic'(c == TO + 1), logic'(c >= TO + 1 + SWEEP)})
        $display("FAIL timeout t+%0d: pulse/mode got %b%b want %b%b", c, bus.drain_timeout_o,
                 bus.checkpoint_mode_o, c == TO + 1, c >= TO + 1 + SWEEP);
      else n_pass++;
    end
    // Counter was zeroed by the timeout, so the exit drain is immediate.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.checkpoint_mode_o, bus.drain_timeout_o} !== 2'b00)
      $display("FAIL timeout_cnt_zero: mode/pulse got %b%b want 00", bus.checkpoint_mode_o, bus.drain_timeout_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    go_home();
    issue_n(5);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 6 + SWEEP; c++) begin
      set_in(1'b0, c == 3, 1'b0, c == 3);
      tick();
      n_total++;
      if (bus.checkpoint_mode_o !== logic'(c + 1 >= 5 + SWEEP))
        $display("FAIL flush t+%0d: mode got %b want %b", c + 1, bus.checkpoint_mode_o, c + 1 >= 5 + SWEEP);
      else n_pass++;
    end
  endtask

  // 10 issues saturate at MAXI=6; six resolves then drain it.
  task automatic test_saturation();
    go_home();
    issue_n(10);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 9 + SWEEP; c++) begin
      set_in(1'b0, 1'b0, c <= 6, 1'b0);
      tick();
      n_total++;
      if (bus.checkpoint_mode_o !== logic'(c + 1 >= 8 + SWEEP))
        $display("FAIL saturate t+%0d: mode got %b want %b", c + 1, bus.checkpoint_mode_o, c + 1 >= 8 + SWEEP);
      else n_pass++;
    end
  endtask

  // Resolves at zero are ignored, so one issue then one resolve drains it.
  task automatic test_underflow();
    go_home();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    issue_n(1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 4 + SWEEP; c++) begin
      set_in(1'b0, 1'b0, c == 1, 1'b0);
      tick();
      n_total++;
      if (bus.checkpoint_mode_o !== logic'(c + 1 >= 3 + SWEEP))
        $display("FAIL underflow t+%0d: mode got %b want %b", c + 1, bus.checkpoint_mode_o, c + 1 >= 3 + SWEEP);
      else n_pass++;
    end
  endtask

  task automatic test_clear_sweep();
    logic [IW+1:0] want;
    go_home();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= NR + 3; c++) begin
      tick();
      want = {logic'(c < 2 + SWEEP), logic'(c >= 2 + SWEEP), IW'(c < 2 + SWEEP ? c - 2 : 0)};
      n_total++;
      if ({bus.clr_valid_o, bus.update_en_o, bus.clr_index_o} !== want)
        $display("FAIL clear t+%0d: valid/upd/idx got %b/%b/%0d want %b/%b/%0d", c, bus.clr_valid_o,
                 bus.update_en_o, bus.clr_index_o, want[IW+1], want[IW], want[IW-1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    go_home();
    issue_n(2);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    if (SWEEP > 0) begin
      while (bus.clr_index_o != IW'(7) && g < 40) begin tick(); g++; end
    end else begin
      tick(); tick();
    end
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (obs_vec() !== RESET_VEC) $display("FAIL reset_mid: got %h want %h", obs_vec(), RESET_VEC);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_RUN_A) $display("FAIL reset_mid_state: got %0d want %0d", dbg_state, ST_RUN_A);
    else n_pass++;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.clr_index_o, bus.clr_valid_o, bus.checkpoint_mode_o} !== {IW'(0), logic'(SWEEP > 0), logic'(SWEEP == 0)})
      $display("FAIL restart_t2: idx/valid/mode got %0d/%b/%b want 0/%b/%b", bus.clr_index_o,
               bus.clr_valid_o, bus.checkpoint_mode_o, SWEEP > 0, SWEEP == 0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] want;
    go_home();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
      tick();
      exp_q.push_back(exp_vec());
      want = exp_q.pop_front();
      n_total++;
      if (obs_vec() !== want) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), want);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_idle_enter();
    test_drain_wait(1'b0);
    test_drain_wait(1'b1);
    test_timeout();
    test_flush();
    test_saturation();
    test_underflow();
    test_clear_sweep();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
